// File: rtl/cache_arbiter.sv
// cache_arbiter
// Arbitrates the I-cache and D-cache line-miss ports onto a single line-wide
// physical-memory port. One transaction is latched at a time, presented to
// memory until pmem_resp, then answered with a one-cycle resp pulse to the
// client that was granted.
//
// Ports
//   clk, rst                     clock (rising edge), async active-high reset
//   icache_read/_address         I-cache line read request
//   icache_resp/_rdata           I-cache completion pulse and returned line
//   dcache_read/_write/_address  D-cache line read / writeback request
//   dcache_wdata                 D-cache writeback line
//   dcache_resp/_rdata           D-cache completion pulse and returned line
//   pmem_read/_write/_address    memory request (address line-aligned)
//   pmem_wdata                   memory writeback line
//   pmem_resp/_rdata             memory completion and read data
//
// Handshake: a client raises read (or write) with address/wdata stable and
// holds it until its resp pulse; the request is then dropped in the following
// cycle. The memory side sees pmem_read/pmem_write held with stable
// address/wdata until it returns pmem_resp (which may be in the same cycle);
// pmem_rdata is only looked at while pmem_resp is high.
module cache_arbiter #(
  parameter int LINE_WIDTH = 256,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  icache_read,
  input  logic [ADDR_WIDTH-1:0] icache_address,
  output logic                  icache_resp,
  output logic [LINE_WIDTH-1:0] icache_rdata,
  input  logic                  dcache_read,
  input  logic                  dcache_write,
  input  logic [ADDR_WIDTH-1:0] dcache_address,
  input  logic [LINE_WIDTH-1:0] dcache_wdata,
  output logic                  dcache_resp,
  output logic [LINE_WIDTH-1:0] dcache_rdata,
  output logic                  pmem_read,
  output logic                  pmem_write,
  output logic [ADDR_WIDTH-1:0] pmem_address,
  output logic [LINE_WIDTH-1:0] pmem_wdata,
  input  logic                  pmem_resp,
  input  logic [LINE_WIDTH-1:0] pmem_rdata
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic CL_I = 1'b0;
  localparam logic CL_D = 1'b1;

  state_t                state;
  state_t                state_next;
  logic                  last_grant;
  logic                  gnt_client;
  logic                  gnt_write;
  logic                  req_i;
  logic                  req_d;
  logic                  grant_client;
  logic [ADDR_WIDTH-1:0] sel_address;

  assign req_i = icache_read;
  assign req_d = dcache_read | dcache_write;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (req_i || req_d) state_next = BUSY;
      BUSY:    if (pmem_resp)      state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Round-robin pick: on a tie the client that was not served last wins.
  always_comb begin
    grant_client = CL_I;
    if (req_i && req_d) begin
      grant_client = ~last_grant;
    end else if (req_d) begin
      grant_client = CL_D;
    end
  end

  assign sel_address = (grant_client == CL_D) ? dcache_address : icache_address;

  // Latched transaction and returned-line registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant   <= CL_I;
      gnt_client   <= CL_I;
      gnt_write    <= 1'b0;
      pmem_address <= '0;
      pmem_wdata   <= '0;
      icache_rdata <= '0;
      dcache_rdata <= '0;
    end else begin
      if (state == IDLE && (req_i || req_d)) begin
        gnt_client   <= grant_client;
        last_grant   <= grant_client;
        // Write wins over an illegal read+write from the D-cache.
        gnt_write    <= (grant_client == CL_D) && dcache_write;
        pmem_address <= {sel_address[ADDR_WIDTH-1:5], 5'b0_0000};
        pmem_wdata   <= dcache_wdata;
      end
      if (state == BUSY && pmem_resp && !gnt_write) begin
        if (gnt_client == CL_I) begin
          icache_rdata <= pmem_rdata;
        end else begin
          dcache_rdata <= pmem_rdata;
        end
      end
    end
  end

  // Outputs decoded from state and latched registers only
  always_comb begin
    pmem_read   = (state == BUSY) && !gnt_write;
    pmem_write  = (state == BUSY) &&  gnt_write;
    icache_resp = (state == DONE) && (gnt_client == CL_I);
    dcache_resp = (state == DONE) && (gnt_client == CL_D);
  end

endmodule

// File: tb/tb_cache_arbiter.sv
// Testbench for cache_arbiter: directed vector table, hand-written reset
// corner case, then randomized traffic against a transaction-level model.
module tb_cache_arbiter;

  localparam int LW = 256;
  localparam int AW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          icache_read;
  logic [AW-1:0] icache_address;
  logic          icache_resp;
  logic [LW-1:0] icache_rdata;
  logic          dcache_read;
  logic          dcache_write;
  logic [AW-1:0] dcache_address;
  logic [LW-1:0] dcache_wdata;
  logic          dcache_resp;
  logic [LW-1:0] dcache_rdata;
  logic          pmem_read;
  logic          pmem_write;
  logic [AW-1:0] pmem_address;
  logic [LW-1:0] pmem_wdata;
  logic          pmem_resp;
  logic [LW-1:0] pmem_rdata;

  cache_arbiter #(.LINE_WIDTH(LW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst),
    .icache_read(icache_read), .icache_address(icache_address),
    .icache_resp(icache_resp), .icache_rdata(icache_rdata),
    .dcache_read(dcache_read), .dcache_write(dcache_write),
    .dcache_address(dcache_address), .dcache_wdata(dcache_wdata),
    .dcache_resp(dcache_resp), .dcache_rdata(dcache_rdata),
    .pmem_read(pmem_read), .pmem_write(pmem_write),
    .pmem_address(pmem_address), .pmem_wdata(pmem_wdata),
    .pmem_resp(pmem_resp), .pmem_rdata(pmem_rdata)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int            n_cmp  = 0;
  int            n_fail = 0;
  logic [LW-1:0] exp_q[$];
  logic [LW-1:0] exp_ird;
  logic [LW-1:0] exp_drd;

  task automatic chk(input string nm, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic logic [LW-1:0] rand_line();
    logic [LW-1:0] v;
    for (int i = 0; i < LW / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic chk_idle_port(input string tag);
    chk({tag, " pmem_read"}, LW'(pmem_read), '0);
    chk({tag, " pmem_write"}, LW'(pmem_write), '0);
  endtask

  task automatic chk_rdata(input string tag);
    chk({tag, " icache_rdata"}, icache_rdata, exp_ird);
    chk({tag, " dcache_rdata"}, dcache_rdata, exp_drd);
  endtask

  // ---------------- directed vectors ----------------
  typedef struct {
    bit          i_rd;
    bit          d_rd;
    bit          d_wr;
    logic [31:0] i_addr;
    logic [31:0] d_addr;
    logic [LW-1:0] wdata;
    int          delay;
    logic [LW-1:0] rdata;
    bit          drop;
    int          exp_cl;   // 0 = I-cache, 1 = D-cache
    bit          exp_wr;
    logic [31:0] exp_addr;
  } vec_t;

  function automatic vec_t mk(bit i_rd, bit d_rd, bit d_wr, logic [31:0] i_addr,
                              logic [31:0] d_addr, logic [LW-1:0] wdata, int delay,
                              logic [LW-1:0] rdata, bit drop, int exp_cl, bit exp_wr,
                              logic [31:0] exp_addr);
    vec_t v;
    v.i_rd = i_rd; v.d_rd = d_rd; v.d_wr = d_wr; v.i_addr = i_addr; v.d_addr = d_addr;
    v.wdata = wdata; v.delay = delay; v.rdata = rdata; v.drop = drop;
    v.exp_cl = exp_cl; v.exp_wr = exp_wr; v.exp_addr = exp_addr;
    return v;
  endfunction

  // Entry: just after the negedge of a cycle in which the DUT is arbitrating.
  // Exit: same point of the next arbitration cycle.
  task automatic do_txn(input vec_t v, input string tag);
    icache_read    = v.i_rd;
    icache_address = v.i_addr;
    dcache_read    = v.d_rd;
    dcache_write   = v.d_wr;
    dcache_address = v.d_addr;
    dcache_wdata   = v.wdata;
    pmem_resp      = 1'b0;
    for (int k = 0; k <= v.delay; k++) begin
      @(negedge clk);
      chk({tag, " pmem_read"}, LW'(pmem_read), LW'(!v.exp_wr));
      chk({tag, " pmem_write"}, LW'(pmem_write), LW'(v.exp_wr));
      chk({tag, " pmem_address"}, LW'(pmem_address), LW'(v.exp_addr));
      if (v.exp_wr) chk({tag, " pmem_wdata"}, pmem_wdata, v.wdata);
      chk({tag, " busy icache_resp"}, LW'(icache_resp), '0);
      chk({tag, " busy dcache_resp"}, LW'(dcache_resp), '0);
      if (v.drop && k == 0) begin
        icache_read = 1'b0; dcache_read = 1'b0; dcache_write = 1'b0;
      end
      pmem_resp  = (k == v.delay);
      pmem_rdata = (k == v.delay) ? v.rdata : rand_line();
      if (k == v.delay && !v.exp_wr) begin
        if (v.exp_cl == 0) exp_ird = v.rdata;
        else               exp_drd = v.rdata;
      end
    end
    @(negedge clk);
    pmem_resp = 1'b0;
    chk({tag, " icache_resp"}, LW'(icache_resp), LW'(v.exp_cl == 0));
    chk({tag, " dcache_resp"}, LW'(dcache_resp), LW'(v.exp_cl == 1));
    chk_idle_port({tag, " done"});
    chk_rdata({tag, " done"});
    if (v.exp_cl == 0) icache_read = 1'b0;
    else begin dcache_read = 1'b0; dcache_write = 1'b0; end
    @(negedge clk);
    chk({tag, " idle icache_resp"}, LW'(icache_resp), '0);
    chk({tag, " idle dcache_resp"}, LW'(dcache_resp), '0);
    chk_idle_port({tag, " idle"});
    chk_rdata({tag, " idle"});
  endtask

  vec_t vecs[8];
  logic [LW-1:0] line_aa;
  logic [LW-1:0] line_55;
  logic [LW-1:0] line_wb;

  // ---------------- random-phase model ----------------
  int            g_cl;
  bit            g_wr;
  logic [AW-1:0] g_addr;
  logic [LW-1:0] g_wdata;
  int            g_start;
  int            g_d;
  int            arb_cyc;
  int            last_w;
  bit            i_out, d_out;
  int            i_hold, d_hold;
  bit            busy, resp_c;

  initial begin
    line_aa = {32{8'hAA}};
    line_55 = {32{8'h55}};
    line_wb = {8{32'h1234_5678}};
    vecs[0] = mk(1, 0, 0, 32'h0000_0047, 32'h0, '0, 0, line_aa, 0, 0, 0, 32'h0000_0040);
    vecs[1] = mk(1, 1, 0, 32'h0000_1000, 32'h0000_2024, '0, 1, line_55, 0, 1, 0, 32'h0000_2020);
    vecs[2] = mk(1, 0, 0, 32'h0000_1000, 32'h0, '0, 0, ~line_55, 0, 0, 0, 32'h0000_1000);
    vecs[3] = mk(1, 1, 0, 32'h0000_3000, 32'h0000_4000, '0, 2, {16{16'hBEEF}}, 0, 1, 0, 32'h0000_4000);
    vecs[4] = mk(1, 0, 0, 32'h0000_3000, 32'h0, '0, 0, {16{16'hCAFE}}, 0, 0, 0, 32'h0000_3000);
    vecs[5] = mk(0, 0, 1, 32'h0, 32'h0000_0100, line_wb, 4, line_aa, 0, 1, 1, 32'h0000_0100);
    vecs[6] = mk(1, 0, 0, 32'h0000_5F5F, 32'h0, '0, 3, {8{32'h0F0F_1234}}, 1, 0, 0, 32'h0000_5F40);
    vecs[7] = mk(0, 1, 1, 32'h0, 32'h0000_02AB, ~line_wb, 2, line_55, 0, 1, 1, 32'h0000_02A0);

    rst = 1'b1;
    icache_read = 0; icache_address = '0;
    dcache_read = 0; dcache_write = 0; dcache_address = '0; dcache_wdata = '0;
    pmem_resp = 0; pmem_rdata = '0;
    exp_ird = '0; exp_drd = '0;

    // Reset state
    @(negedge clk);
    chk_idle_port("reset");
    chk("reset icache_resp", LW'(icache_resp), '0);
    chk("reset dcache_resp", LW'(dcache_resp), '0);
    chk("reset pmem_address", LW'(pmem_address), '0);
    chk("reset pmem_wdata", pmem_wdata, '0);
    chk_rdata("reset");
    rst = 1'b0;
    @(negedge clk);

    // Directed table
    for (int i = 0; i < 8; i++) do_txn(vecs[i], $sformatf("vec%0d", i));

    // Reset during a D-cache read while pmem_read is high
    dcache_read = 1'b1; dcache_address = 32'h0000_0BEE;
    @(negedge clk);
    chk("rstbusy pmem_read before", LW'(pmem_read), 1);
    #2 rst = 1'b1;
    #1;
    chk_idle_port("rstbusy");
    chk("rstbusy pmem_address", LW'(pmem_address), '0);
    chk("rstbusy pmem_wdata", pmem_wdata, '0);
    chk("rstbusy icache_resp", LW'(icache_resp), '0);
    chk("rstbusy dcache_resp", LW'(dcache_resp), '0);
    exp_ird = '0; exp_drd = '0;
    chk_rdata("rstbusy");
    @(negedge clk);
    rst = 1'b0; dcache_read = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("postrst icache_resp", LW'(icache_resp), '0);
      chk("postrst dcache_resp", LW'(dcache_resp), '0);
      chk_idle_port("postrst");
    end
    // Tie right after reset goes to the D-cache, then the held I-cache
    do_txn(mk(1, 1, 0, 32'h0000_7000, 32'h0000_8008, '0, 0, line_aa, 0, 1, 0, 32'h0000_8000), "rsttie");
    do_txn(mk(1, 0, 0, 32'h0000_7000, 32'h0, '0, 1, line_55, 0, 0, 0, 32'h0000_7000), "rsttie2");

    // Randomized traffic; cycle 0 is an arbitration cycle, last grant was I
    g_cl = -1; g_wr = 0; g_addr = '0; g_wdata = '0; g_start = 0; g_d = 0;
    arb_cyc = 0; last_w = 0;
    i_out = 0; d_out = 0; i_hold = 0; d_hold = 0;
    for (int c = 0; c < 3000; c++) begin
      if (c > 0) @(negedge clk);
      busy   = (g_cl >= 0) && c >= g_start && c <= g_start + g_d;
      resp_c = (g_cl >= 0) && c == g_start + g_d + 1;
      chk("rnd pmem_read", LW'(pmem_read), LW'(busy && !g_wr));
      chk("rnd pmem_write", LW'(pmem_write), LW'(busy && g_wr));
      chk("rnd icache_resp", LW'(icache_resp), LW'(resp_c && g_cl == 0));
      chk("rnd dcache_resp", LW'(dcache_resp), LW'(resp_c && g_cl == 1));
      if (g_cl >= 0) chk("rnd pmem_address", LW'(pmem_address), LW'({g_addr[AW-1:5], 5'b0}));
      if (busy && g_wr) chk("rnd pmem_wdata", pmem_wdata, g_wdata);
      if (resp_c && !g_wr) begin
        if (exp_q.size() == 0) chk("rnd exp_q empty", 1, 0);
        else if (g_cl == 0) chk("rnd sb icache_rdata", icache_rdata, exp_q.pop_front());
        else                chk("rnd sb dcache_rdata", dcache_rdata, exp_q.pop_front());
      end
      chk_rdata("rnd");

      // Memory responder
      pmem_resp  = busy && (c == g_start + g_d);
      pmem_rdata = rand_line();
      if (pmem_resp && !g_wr) begin
        exp_q.push_back(pmem_rdata);
        if (g_cl == 0) exp_ird = pmem_rdata;
        else           exp_drd = pmem_rdata;
      end

      // I-cache client
      if (resp_c && g_cl == 0) begin
        icache_read = 0; i_out = 0; i_hold = c + 2;
      end else if (busy && g_cl == 0 && $urandom_range(0, 7) == 0) begin
        icache_read = 0;
      end else if (!i_out && c >= i_hold && $urandom_range(0, 2) == 0) begin
        icache_read = 1; icache_address = $urandom; i_out = 1;
      end
      // D-cache client (op 3 is the illegal read+write)
      if (resp_c && g_cl == 1) begin
        dcache_read = 0; dcache_write = 0; d_out = 0; d_hold = c + 2;
      end else if (busy && g_cl == 1 && $urandom_range(0, 7) == 0) begin
        dcache_read = 0; dcache_write = 0;
      end else if (!d_out && c >= d_hold && $urandom_range(0, 2) == 0) begin
        case ($urandom_range(0, 3))
          0, 1:    begin dcache_read = 1; dcache_write = 0; end
          2:       begin dcache_read = 0; dcache_write = 1; end
          default: begin dcache_read = 1; dcache_write = 1; end
        endcase
        dcache_address = $urandom; dcache_wdata = rand_line(); d_out = 1;
      end

      // Arbitration happens in the cycle after DONE (or any idle cycle)
      if (c == arb_cyc) begin
        if (icache_read || dcache_read || dcache_write) begin
          if (icache_read && (dcache_read || dcache_write)) g_cl = 1 - last_w;
          else if (icache_read) g_cl = 0;
          else g_cl = 1;
          g_wr    = (g_cl == 1) && dcache_write;
          g_addr  = (g_cl == 1) ? dcache_address : icache_address;
          g_wdata = dcache_wdata;
          g_d     = $urandom_range(0, 4);
          g_start = c + 1;
          arb_cyc = c + 3 + g_d;
          last_w  = g_cl;
        end else begin
          arb_cyc = c + 1;
        end
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
